// File: rtl/writeback_regfile_pkg.sv
// Shared Y86-64 definitions: icodes, register specifiers and status codes.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  // Status codes double as the writeback state encoding (AOK is the RUN state).
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// Bus between the upstream pipeline/decode logic and the writeback stage.
// `WB_RETIRE_CNT_EN adds the retired-instruction counter output.
interface writeback_regfile_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        Cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        instr_valid;
  logic        imem_error;
  logic        dmem_error;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [2:0]  Stat;
  logic        halted;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired;

  modport master (
    output icode, rA, rB, Cnd, valE, valM, instr_valid, imem_error, dmem_error, srcA, srcB,
    input  valA, valB, Stat, halted, retired
  );
  modport slave (
    input  icode, rA, rB, Cnd, valE, valM, instr_valid, imem_error, dmem_error, srcA, srcB,
    output valA, valB, Stat, halted, retired
  );
`else
  modport master (
    output icode, rA, rB, Cnd, valE, valM, instr_valid, imem_error, dmem_error, srcA, srcB,
    input  valA, valB, Stat, halted
  );
  modport slave (
    input  icode, rA, rB, Cnd, valE, valM, instr_valid, imem_error, dmem_error, srcA, srcB,
    output valA, valB, Stat, halted
  );
`endif
endinterface

// File: rtl/writeback_regfile_regfile.sv
// 15x64 program register file: two combinational read ports, two write ports (M beats E).
module regfile_15x64
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs [0:14];

  assign val_a = (src_a == RNONE) ? 64'd0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? 64'd0 : regs[src_b];

  // The M write is issued last so it overrides E when both target the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'd0;
      end
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// SEQ Y86-64 writeback stage: destination decode, sticky status FSM and register file.
// Optional `WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd512
) (
  input logic              clk,
  input logic              reset,
  writeback_regfile_if.slave bus
);

  logic [3:0] dst_e;
  logic [3:0] dst_m;
  stat_t      instr_stat;
  stat_t      state;
  stat_t      state_next;
  logic       commit;

  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.icode)
      IRRMOVQ:               if (bus.Cnd) dst_e = bus.rB;
      IIRMOVQ, IOPQ:         dst_e = bus.rB;
      ICALL, IRET, IPUSHQ:   dst_e = RRSP;
      IPOPQ: begin
        dst_e = RRSP;
        dst_m = bus.rA;
      end
      IMRMOVQ:               dst_m = bus.rA;
      default: ;
    endcase
  end

  always_comb begin
    instr_stat = STAT_AOK;
    if (bus.imem_error || bus.dmem_error) instr_stat = STAT_ADR;
    else if (!bus.instr_valid)            instr_stat = STAT_INS;
    else if (bus.icode == IHALT)          instr_stat = STAT_HLT;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= STAT_AOK;
    else       state <= state_next;
  end

  // Any non-AOK state is absorbing until reset.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    if (state == STAT_AOK) begin
      if (instr_stat == STAT_AOK) commit     = 1'b1;
      else                        state_next = instr_stat;
    end
  end

  regfile_15x64 #(.RSP_INIT(RSP_INIT)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .src_a (bus.srcA),
    .src_b (bus.srcB),
    .val_a (bus.valA),
    .val_b (bus.valB),
    .dst_e (commit ? dst_e : RNONE),
    .val_e (bus.valE),
    .dst_m (commit ? dst_m : RNONE),
    .val_m (bus.valM)
  );

  assign bus.Stat   = state;
  assign bus.halted = (state != STAT_AOK);

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired_cnt;

  always_ff @(posedge clk) begin
    if (reset)       retired_cnt <= 64'd0;
    else if (commit) retired_cnt <= retired_cnt + 64'd1;
  end

  assign bus.retired = retired_cnt;
`endif

endmodule
